// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus responder: FSM encoding, bus widths, byte-lane indices.
package sram_pkg;

  localparam int DQ_W    = 16;
  localparam int ADDR_W  = 18;
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_DRIVE = 2'd2,
    ST_WR_WAIT  = 2'd3
  } sram_state_t;

  // Merge new data into an old word, one byte per enabled lane.
  function automatic logic [DQ_W-1:0] lane_merge(input logic [DQ_W-1:0] old_w,
                                                 input logic [DQ_W-1:0] new_w,
                                                 input logic [1:0]      be);
    logic [DQ_W-1:0] res;
    res = old_w;
    if (be[LANE_LO]) res[7:0]  = new_w[7:0];
    if (be[LANE_HI]) res[15:8] = new_w[15:8];
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Word storage for the responder: 2**MEM_AW x 16, synchronous byte-enable write, asynchronous read.
module sram_resp_array
  import sram_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic              i_we,
  input  logic [1:0]        i_be,
  input  logic [DQ_W-1:0]   i_wdata,
  output logic [DQ_W-1:0]   o_rdata
);

  logic [DQ_W-1:0] r_mem [2**MEM_AW];

  // No reset on the array: contents survive a bus reset, like the real chip.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= lane_merge(r_mem[i_addr], i_wdata, i_be);
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sram_responder.sv
// Device-side model of the 16-bit async SRAM bus with configurable read/write latency.
// Optional protocol checker enabled by defining SRAM_RESP_ERRCHK_EN; otherwise err is tied low.
module sram_responder
  import sram_pkg::*;
#(
  parameter int MEM_AW    = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              busy,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam sram_state_t RD_ENTRY = (READ_LAT == 1) ? ST_RD_DRIVE : ST_RD_WAIT;

  sram_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic              w_rd;
  logic              w_wr;
  logic              w_same;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_we;
  logic [1:0]        w_be;
  logic [DQ_W-1:0]   w_rdata;
  logic              w_drive;

  // WR wins over RD when OE_N and WE_N are both low.
  assign w_wr      = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd      = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign w_same    = (SRAM_ADDR == r_addr);
  assign w_rd_done = (int'(r_cnt) + 1) >= READ_LAT;
  assign w_wr_done = (int'(r_cnt) + 1) >= WRITE_LAT;
  assign w_be      = {!SRAM_UB_N, !SRAM_LB_N};

  assign w_we = (r_state == ST_WR_WAIT) && w_wr && w_same && w_wr_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr) begin
            r_addr  <= SRAM_ADDR;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_WR_WAIT;
          end else if (w_rd) begin
            r_addr  <= SRAM_ADDR;
            r_cnt   <= CNT_W'(1);
            r_state <= RD_ENTRY;
          end
        end
        ST_RD_WAIT: begin
          if (!w_rd) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (!w_same) begin
            r_addr <= SRAM_ADDR;
            r_cnt  <= CNT_W'(1);
          end else if (w_rd_done) begin
            r_cnt   <= '0;
            r_state <= ST_RD_DRIVE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RD_DRIVE: begin
          if (!w_rd) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (!w_same) begin
            r_addr  <= SRAM_ADDR;
            r_cnt   <= CNT_W'(1);
            r_state <= RD_ENTRY;
          end
        end
        ST_WR_WAIT: begin
          if (!w_wr || w_wr_done && w_same) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (!w_same) begin
            r_addr <= SRAM_ADDR;
            r_cnt  <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  sram_resp_array #(.MEM_AW(MEM_AW)) u_array (
    .clk     (clk),
    .i_addr  (r_addr[MEM_AW-1:0]),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_wdata (SRAM_DQ),
    .o_rdata (w_rdata)
  );

  // Release DQ in the same cycle the read request drops or moves address.
  assign w_drive = (r_state == ST_RD_DRIVE) && w_rd && w_same;
  assign SRAM_DQ[15:8] = (w_drive && !SRAM_UB_N) ? w_rdata[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (w_drive && !SRAM_LB_N) ? w_rdata[7:0]  : 8'hzz;

  assign busy        = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
  assign o_dbg_state = r_state;

`ifdef SRAM_RESP_ERRCHK_EN
  logic r_err;
  logic w_accept;
  logic w_conflict;
  logic w_xz;

  assign w_accept = ((r_state == ST_IDLE) && (w_rd || w_wr)) ||
                    ((r_state == ST_RD_WAIT || r_state == ST_RD_DRIVE) && w_rd && !w_same) ||
                    ((r_state == ST_WR_WAIT) && w_wr && !w_same);
  assign w_conflict = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;
  assign w_xz       = w_we && $isunknown(SRAM_DQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_conflict || w_xz || (w_accept && SRAM_UB_N && SRAM_LB_N)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: driver tasks on the bus, negedge monitor scoring read data from a queue.
module tb_sram_responder;
  import sram_pkg::*;

  localparam int READ_LAT = 2;

`ifdef SRAM_RESP_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DQ_W-1:0]   sram_dq;
  logic              ub_n, lb_n, we_n, ce_n, oe_n;
  logic              busy, err;
  logic [1:0]        dbg_state;
  logic [DQ_W-1:0]   dq_drv;
  logic              dq_oe;
  logic              mon_en;

  int checks   = 0;
  int failures = 0;

  // {lane enables [hi,lo], data}
  logic [17:0] exp_q[$];

  assign sram_dq = dq_oe ? dq_drv : 16'hzzzz;

  sram_responder #(.MEM_AW(8), .READ_LAT(READ_LAT), .WRITE_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ     (sram_dq),
    .SRAM_UB_N   (ub_n),
    .SRAM_LB_N   (lb_n),
    .SRAM_WE_N   (we_n),
    .SRAM_CE_N   (ce_n),
    .SRAM_OE_N   (oe_n),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // A read response is any cycle where the DUT drives a 1 onto DQ while the bench is not driving.
  always @(negedge clk) begin
    if (mon_en && !dq_oe && ((|sram_dq) === 1'b1)) begin
      logic [17:0]     e;
      logic [DQ_W-1:0] got;
      logic            ok;
      got = sram_dq;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dq_unexpected: got %h expected no drive", got);
      end else begin
        e  = exp_q.pop_front();
        ok = 1'b1;
        if (e[17]) ok = ok && (got[15:8] === e[15:8]);
        else       ok = ok && (got[15:8] === 8'hzz || got[15:8] === 8'h00);
        if (e[16]) ok = ok && (got[7:0] === e[7:0]);
        else       ok = ok && (got[7:0] === 8'hzz || got[7:0] === 8'h00);
        if (!ok) begin
          failures++;
          $display("FAIL dq_read: got %h expected %h lanes %b", got, e[15:0], e[17:16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n  = 1'b1;
    we_n  = 1'b1;
    oe_n  = 1'b1;
    ub_n  = 1'b0;
    lb_n  = 1'b0;
    dq_oe = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                          input logic u_n, input logic l_n, input int hold);
    sram_addr = a;
    dq_drv    = d;
    dq_oe     = 1'b1;
    ub_n      = u_n;
    lb_n      = l_n;
    ce_n      = 1'b0;
    we_n      = 1'b0;
    oe_n      = 1'b1;
    repeat (hold) step();
    bus_idle();
    step();
  endtask

  // Holds RD through READ_LAT edges plus one drive cycle; exactly one response expected.
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic u_n, input logic l_n,
                         input logic [15:0] exp);
    exp_q.push_back({!u_n, !l_n, exp});
    sram_addr = a;
    ub_n      = u_n;
    lb_n      = l_n;
    ce_n      = 1'b0;
    we_n      = 1'b1;
    oe_n      = 1'b0;
    step();
    check("busy_rd_wait", {31'd0, busy}, 32'd1);
    repeat (READ_LAT - 1) step();
    step();
    bus_idle();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mon_en    = 1'b0;
    rst       = 1'b0;
    sram_addr = '0;
    dq_drv    = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_dq_released", {31'd0, ((|sram_dq) === 1'b1)}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    step();

    // Full write then read back
    do_write(18'd5, 16'hA55A, 1'b0, 1'b0, 2);
    do_read(18'd5, 1'b0, 1'b0, 16'hA55A);

    // Byte lanes
    do_write(18'd7, 16'hFFFF, 1'b0, 1'b0, 2);
    do_write(18'd7, 16'h1234, 1'b1, 1'b0, 2);
    do_read(18'd7, 1'b0, 1'b0, 16'hFF34);
    do_write(18'd7, 16'hBEEF, 1'b0, 1'b1, 2);
    do_read(18'd7, 1'b0, 1'b0, 16'hBE34);
    do_read(18'd7, 1'b1, 1'b0, 16'h0034);

    // Aborted write leaves old data
    do_write(18'd9, 16'h9999, 1'b0, 1'b0, 2);
    do_write(18'd9, 16'h1111, 1'b0, 1'b0, 1);
    do_read(18'd9, 1'b0, 1'b0, 16'h9999);

    // Address change during RD_WAIT restarts the latency
    do_write(18'd3, 16'h3333, 1'b0, 1'b0, 2);
    do_write(18'd4, 16'h4444, 1'b0, 1'b0, 2);
    exp_q.push_back({2'b11, 16'h4444});
    sram_addr = 18'd3;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    step();
    sram_addr = 18'd4;
    step();
    check("busy_restart", {31'd0, busy}, 32'd1);
    step();
    step();
    bus_idle();
    step();
    check("idle_after_read", {31'd0, busy}, 32'd0);

    // Aliasing: 0x100 maps to word 0
    do_write(18'h100, 16'hCAFE, 1'b0, 1'b0, 2);
    do_read(18'd0, 1'b0, 1'b0, 16'hCAFE);

    // Reset while driving releases DQ at once
    exp_q.push_back({2'b11, 16'hCAFE});
    sram_addr = 18'd0;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_dq", {31'd0, ((|sram_dq) === 1'b1)}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    check("rst_mid_dq_edge", {31'd0, ((|sram_dq) === 1'b1)}, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    bus_idle();
    @(negedge clk);
    rst = 1'b1;
    step();

    // CE/WE/OE all low: checker flags it, access still commits as a write
    sram_addr = 18'd12;
    dq_drv = 16'h7777; dq_oe = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    step();
    oe_n = 1'b1;
    step();
    bus_idle();
    step();
    check("err_conflict", {31'd0, err}, {31'd0, ERR_EXP});
    do_read(18'd12, 1'b0, 1'b0, 16'h7777);
    do_write(18'd13, 16'h0101, 1'b0, 1'b0, 2);
    check("err_sticky", {31'd0, err}, {31'd0, ERR_EXP});
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("err_cleared", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
